// File: rtl/aes_block_uart_serializer_if.sv
// ---------------------------------------------------------------------------
// aes_block_uart_serializer_if
// Bundles the block-input handshake and the UART transmitter hookup of the
// AES block serializer.
//
//   blk_data_i     [127:0]  block to send, byte 0 in bits [7:0]
//   blk_valid_i             producer has a block on blk_data_i
//   blk_ready_o             serializer FIFO can take a block
//   tx_din_o       [7:0]    byte to the UART transmitter
//   tx_start_o              one-cycle start pulse to the UART transmitter
//   tx_done_tick_i          UART transmitter finished a byte (stop bit incl.)
//   busy_o                  FIFO non-empty or a block is being sent
//   frame_done_o            one-cycle pulse at the end of every frame
//   blocks_sent_o  [CNT_W-1:0] blocks completed since reset (wrapping)
//
// slave  : the serializer itself
// master : the environment (AES producer + UART transmitter)
// ---------------------------------------------------------------------------
interface aes_block_uart_serializer_if #(
    parameter int CNT_W = 16
);
    logic [127:0]     blk_data_i;
    logic             blk_valid_i;
    logic             blk_ready_o;
    logic [7:0]       tx_din_o;
    logic             tx_start_o;
    logic             tx_done_tick_i;
    logic             busy_o;
    logic             frame_done_o;
    logic [CNT_W-1:0] blocks_sent_o;

    modport slave (
        input  blk_data_i, blk_valid_i, tx_done_tick_i,
        output blk_ready_o, tx_din_o, tx_start_o, busy_o, frame_done_o,
               blocks_sent_o
    );

    modport master (
        output blk_data_i, blk_valid_i, tx_done_tick_i,
        input  blk_ready_o, tx_din_o, tx_start_o, busy_o, frame_done_o,
               blocks_sent_o
    );
endinterface

// File: rtl/aes_block_uart_serializer.sv
// ---------------------------------------------------------------------------
// aes_block_uart_serializer
// Streams 128-bit AES result blocks out through a byte-wide UART
// transmitter, least-significant byte first, one byte per tx_done_tick.
// A FIFO_DEPTH-entry block FIFO decouples the AES cores from the UART.
//
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous, active-high; clears all state
//   bus    aes_block_uart_serializer_if.slave
//            blk_data_i/blk_valid_i/blk_ready_o : block push handshake
//            tx_din_o/tx_start_o/tx_done_tick_i : UART transmitter hookup
//            busy_o, frame_done_o, blocks_sent_o: status
//
// Timing: a block pushed into an empty FIFO while idle is popped on the next
// edge and its first tx_start_o is visible one edge later. Each following
// byte starts two cycles after the previous done tick; the next block's first
// byte starts three cycles after the last tick of the previous block.
// ---------------------------------------------------------------------------
module aes_block_uart_serializer #(
    parameter int FIFO_DEPTH   = 2,   // power of 2, >= 2
    parameter int FRAME_BLOCKS = 4,
    parameter int CNT_W        = 16
) (
    input logic                        clk,
    input logic                        reset,
    aes_block_uart_serializer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FRAME_BLOCKS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t           state_q, state_d;

    logic [127:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;

    logic [127:0]     shreg_q;
    logic [3:0]       byte_idx_q;
    logic [7:0]       tx_din_q;
    logic             tx_start_q;
    logic             frame_done_q;
    logic [CNT_W-1:0] blocks_q;
    logic [FW-1:0]    frame_cnt_q;

    logic             fifo_empty;
    logic             push, pop;
    logic             load_byte;   // S_START: hand shreg[7:0] to the UART
    logic             next_byte;   // tick on bytes 0..14: shift to next byte
    logic             blk_done;    // tick on byte 15: block finished

    assign fifo_empty      = (count_q == '0);
    assign bus.blk_ready_o = (count_q < (AW+1)'(FIFO_DEPTH));
    assign push            = bus.blk_valid_i & bus.blk_ready_o;

    assign bus.tx_din_o      = tx_din_q;
    assign bus.tx_start_o    = tx_start_q;
    assign bus.frame_done_o  = frame_done_q;
    assign bus.blocks_sent_o = blocks_q;
    assign bus.busy_o        = !fifo_empty || (state_q != S_IDLE);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        load_byte = 1'b0;
        next_byte = 1'b0;
        blk_done  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                load_byte = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // Ticks are only meaningful here; in other states the UART is
                // idle and a tick is ignored.
                if (bus.tx_done_tick_i) begin
                    if (byte_idx_q == 4'd15) begin
                        blk_done = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        next_byte = 1'b1;
                        state_d   = S_START;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Block FIFO
    // -----------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only read after it has
    // been written, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.blk_data_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            // Simultaneous push and pop leaves the occupancy unchanged.
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Byte shifter, UART drive and block/frame accounting
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q      <= '0;
            byte_idx_q   <= '0;
            tx_din_q     <= '0;
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            blocks_q     <= '0;
            frame_cnt_q  <= '0;
        end else begin
            if (pop) begin
                shreg_q    <= fifo_mem[rd_ptr_q];
                byte_idx_q <= '0;
            end else if (next_byte) begin
                shreg_q    <= shreg_q >> 8;
                byte_idx_q <= byte_idx_q + 1'b1;
            end

            // tx_din_o only changes together with a start pulse, so it stays
            // stable for the whole byte.
            tx_start_q <= load_byte;
            if (load_byte) tx_din_q <= shreg_q[7:0];

            frame_done_q <= 1'b0;
            if (blk_done) begin
                blocks_q <= blocks_q + 1'b1;
                if (frame_cnt_q == FW'(FRAME_BLOCKS - 1)) begin
                    frame_done_q <= 1'b1;
                    frame_cnt_q  <= '0;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
            end
        end
    end
endmodule
